fifo_write_arbiter: RTL and testbench

//  Write-side controller for the 8-entry CDC FIFO memory, write_clk domain.

---
 rtl/fifo_write_arbiter.sv | 57 +++++
 tb/tb_fifo_write_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin write side of an 8-entry CDC FIFO (write_clk domain)
module fifo_write_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  write_clk,
  input  logic                  write_rst_n,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] read_ptr_gray_in,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] write_ptr_gray,
  output logic                  full,
  output logic                  last_grant
);
  logic [SYNC_STAGES-1:0][ADDR_WIDTH-1:0] sync_q;
  logic [ADDR_WIDTH-1:0] rptr_sync, wptr_bin_q, wptr_bin_d, wptr_gray_q, wptr_gray_d;
  logic last_grant_q, last_grant_d, gnt0, gnt1, xfer;
  assign rptr_sync = sync_q[SYNC_STAGES-1];
  // Full when the write pointer has lapped the read pointer exactly once
  assign full = wptr_gray_q == {~rptr_sync[ADDR_WIDTH-1 -: 2], rptr_sync[ADDR_WIDTH-3:0]};
  always_comb begin
    gnt0 = write_rst_n & ~full & req0_valid & (~req1_valid | last_grant_q);
    gnt1 = write_rst_n & ~full & req1_valid & (~req0_valid | ~last_grant_q);
    xfer = gnt0 | gnt1;
    wptr_bin_d = xfer ? wptr_bin_q + 1'b1 : wptr_bin_q;
    wptr_gray_d = wptr_bin_d ^ (wptr_bin_d >> 1);
    last_grant_d = xfer ? gnt1 : last_grant_q;
  end
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign mem_write_enable = xfer;
  assign mem_write_data = gnt1 ? req1_data : req0_data;
  assign mem_write_addr = wptr_bin_q;
  assign write_ptr_gray = wptr_gray_q;
  assign last_grant = last_grant_q;
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      sync_q <= '0;
      wptr_bin_q <= '0;
      wptr_gray_q <= '0;
      last_grant_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], read_ptr_gray_in};
      wptr_bin_q <= wptr_bin_d;
      wptr_gray_q <= wptr_gray_d;
      last_grant_q <= last_grant_d;
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: scoreboard bench for the FIFO write-side arbiter
module tb_fifo_write_arbiter;
  logic       clk = 1'b0;
  logic       write_rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data, mem_write_data;
  logic [3:0] rptr, mem_write_addr, write_ptr_gray;
  logic       mem_write_enable, full, last_grant;
  logic [11:0] sb[$];
  logic [11:0] exp_w;
  logic [3:0] m_wptr, prev_gray;
  logic       m_lg, gexp;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter dut (
    .write_clk(clk), .write_rst_n(write_rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .read_ptr_gray_in(rptr), .mem_write_data(mem_write_data),
    .mem_write_addr(mem_write_addr), .mem_write_enable(mem_write_enable),
    .write_ptr_gray(write_ptr_gray), .full(full), .last_grant(last_grant)
  );

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Every memory write must match the oldest expected {addr,data}
  always @(negedge clk) begin
    if (write_rst_n && mem_write_enable) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h", mem_write_addr, mem_write_data);
      end else begin
        exp_w = sb.pop_front();
        if ({mem_write_addr, mem_write_data} !== exp_w) begin
          failures++;
          $display("FAIL mem_write got=%h/%h want=%h/%h", mem_write_addr, mem_write_data, exp_w[11:8], exp_w[7:0]);
        end
      end
    end
  end

  task automatic test_reset;
    write_rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0; rptr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({full, write_ptr_gray, last_grant, mem_write_enable, mem_write_addr, req0_ready, req1_ready} !== 13'b0_0000_1_0_0000_00) begin
      failures++;
      $display("FAIL reset_state full=%b gray=%b lg=%b en=%b addr=%h rdy=%b%b want full=0 gray=0000 lg=1 en=0 addr=0 rdy=00",
               full, write_ptr_gray, last_grant, mem_write_enable, mem_write_addr, req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    write_rst_n = 1'b1; m_wptr = '0; m_lg = 1'b1;
  endtask

  task automatic test_fill;
    for (int i = 0; i < 8; i++) begin
      req0_valid = 1'b1; req0_data = 8'(8'h10 + i);
      sb.push_back({m_wptr, req0_data});
      @(negedge clk);
      checks++;
      if ({req0_ready, full} !== 2'b10) begin
        failures++;
        $display("FAIL fill_ready[%0d] ready=%b full=%b want ready=1 full=0", i, req0_ready, full);
      end
      @(posedge clk); #1;
      m_wptr++; m_lg = 1'b0;
    end
    req0_data = 8'h18;
    @(negedge clk);
    checks++;
    if ({full, req0_ready, mem_write_enable, write_ptr_gray} !== 7'b1_0_0_1100) begin
      failures++;
      $display("FAIL fill_full full=%b ready=%b en=%b gray=%b want 1 0 0 1100", full, req0_ready, mem_write_enable, write_ptr_gray);
    end
  endtask

  task automatic test_full_release;
    @(posedge clk); #1;
    rptr = 4'b0001;
    for (int e = 0; e < 2; e++) begin
      @(negedge clk);
      checks++;
      if ({full, req0_ready} !== 2'b10) begin
        failures++;
        $display("FAIL full_hold[%0d] full=%b ready=%b want full=1 ready=0", e, full, req0_ready);
      end
      @(posedge clk); #1;
    end
    sb.push_back({m_wptr, req0_data});
    @(negedge clk);
    checks++;
    if ({full, req0_ready, mem_write_addr} !== 6'b0_1_1000) begin
      failures++;
      $display("FAIL full_release full=%b ready=%b addr=%b want 0 1 1000", full, req0_ready, mem_write_addr);
    end
    @(posedge clk); #1;
    m_wptr++; req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({full, write_ptr_gray} !== 5'b1_1101) begin
      failures++;
      $display("FAIL refull full=%b gray=%b want 1 1101", full, write_ptr_gray);
    end
  endtask

  task automatic test_wrap;
    rptr = gray(m_wptr);
    repeat (3) @(posedge clk);
    #1;
    prev_gray = write_ptr_gray;
    for (int i = 0; i < 20; i++) begin
      req0_valid = 1'b1; req0_data = 8'($urandom); rptr = gray(m_wptr);
      sb.push_back({m_wptr, req0_data});
      @(negedge clk);
      checks++;
      if ({req0_ready, full} !== 2'b10) begin
        failures++;
        $display("FAIL wrap_ready[%0d] ready=%b full=%b want ready=1 full=0", i, req0_ready, full);
      end
      @(posedge clk); #1;
      m_wptr++; m_lg = 1'b0;
      checks++;
      if (write_ptr_gray !== gray(m_wptr) || $countones(write_ptr_gray ^ prev_gray) != 1) begin
        failures++;
        $display("FAIL wrap_gray[%0d] got=%b prev=%b want=%b", i, write_ptr_gray, prev_gray, gray(m_wptr));
      end
      prev_gray = write_ptr_gray;
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_interleave;
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_data = 8'($urandom); req1_data = 8'($urandom); rptr = gray(m_wptr);
      gexp = ~m_lg;
      sb.push_back({m_wptr, gexp ? req1_data : req0_data});
      @(negedge clk);
      checks++;
      if ({req0_ready, req1_ready} !== {~gexp, gexp}) begin
        failures++;
        $display("FAIL rr_grant[%0d] rdy=%b%b want=%b%b", i, req0_ready, req1_ready, ~gexp, gexp);
      end
      @(posedge clk); #1;
      m_wptr++; m_lg = gexp;
      checks++;
      if (last_grant !== m_lg) begin
        failures++;
        $display("FAIL rr_last_grant[%0d] got=%b want=%b", i, last_grant, m_lg);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_req1_only;
    for (int i = 0; i < 5; i++) begin
      req1_valid = 1'b1; req1_data = 8'($urandom); rptr = gray(m_wptr);
      sb.push_back({m_wptr, req1_data});
      @(negedge clk);
      checks++;
      if ({req0_ready, req1_ready, mem_write_enable} !== 3'b011) begin
        failures++;
        $display("FAIL req1_only[%0d] rdy=%b%b en=%b want 01 1", i, req0_ready, req1_ready, mem_write_enable);
      end
      @(posedge clk); #1;
      m_wptr++; m_lg = 1'b1;
      checks++;
      if (last_grant !== 1'b1) begin
        failures++;
        $display("FAIL req1_last_grant[%0d] got=%b want=1", i, last_grant);
      end
    end
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1'b1; req0_data = 8'(8'hA0 + i); rptr = gray(m_wptr);
      sb.push_back({m_wptr, req0_data});
      @(posedge clk); #1;
      m_wptr++; m_lg = 1'b0;
    end
    req0_data = 8'hEE; write_rst_n = 1'b0; rptr = '0;
    #1;
    checks++;
    if ({mem_write_enable, mem_write_addr, write_ptr_gray, last_grant, req0_ready} !== 11'b0_0000_0000_1_0) begin
      failures++;
      $display("FAIL mid_reset en=%b addr=%h gray=%b lg=%b rdy=%b want 0 0 0000 1 0",
               mem_write_enable, mem_write_addr, write_ptr_gray, last_grant, req0_ready);
    end
    m_wptr = '0; m_lg = 1'b1;
    @(posedge clk); #1;
    write_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req0_data = 8'(8'hB0 + i); rptr = gray(m_wptr);
      sb.push_back({m_wptr, req0_data});
      @(negedge clk);
      checks++;
      if ({req0_ready, mem_write_addr} !== {1'b1, m_wptr}) begin
        failures++;
        $display("FAIL restart[%0d] ready=%b addr=%h want 1 %h", i, req0_ready, mem_write_addr, m_wptr);
      end
      @(posedge clk); #1;
      m_wptr++;
    end
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_release();
    test_wrap();
    test_interleave();
    test_req1_only();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
